// File: rtl/pe_sequencer.sv
// Instruction sequencer for a small PE array: fetches 16-bit instructions and
// drives clear / operand-read / accumulate / result-write strobes to the datapath.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start after reset
// FETCH  | instruction read issued at pc
// DECODE | instruction word on inst_data, dispatch on opcode
// CLR    | one-cycle clear of all PE accumulators
// MAC    | one operand read per cycle, op_k = 0..K-1
// DRAIN  | lets the last delayed pe_acc_en fire before advancing pc
// STORE  | four result-row writes, res_row = 0..3
// DONE   | program finished (stop sticky), start restarts at pc 0
module pe_sequencer #(
    parameter int ADDR_W = 8,
    parameter int KMAX   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_rd_en,
    input  logic [15:0]       inst_data,
    output logic              op_rd_en,
    output logic [1:0]        op_k,
    output logic              pe_clr,
    output logic              pe_acc_en,
    output logic              res_wr_en,
    output logic [1:0]        res_row,
    output logic              busy,
    output logic              stop,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_CLR   = 4'h1;
    localparam logic [3:0] OP_MAC   = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [1:0] K_LIM    = 2'(KMAX - 1);

    state_t            state;
    state_t            next_state;
    state_t            adv_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_adv;
    logic [1:0]        step;
    logic [1:0]        step_next;
    logic [1:0]        k_last;
    logic [1:0]        k_last_next;
    logic [1:0]        k_op;
    logic              err_next;
    logic              adv_err;

    logic [ADDR_W-1:0] inst_addr_d;
    logic              inst_rd_en_d;
    logic              op_rd_en_d;
    logic [1:0]        op_k_d;
    logic              pe_clr_d;
    logic              res_wr_en_d;
    logic [1:0]        res_row_d;
    logic              busy_d;
    logic              stop_d;

    logic              unused_operand;
    assign unused_operand = ^inst_data[11:2];

    assign k_op = (inst_data[1:0] > K_LIM) ? K_LIM : inst_data[1:0];

    // Moving past the last address ends the program with an error rather than wrapping.
    always_comb begin
        adv_state = S_FETCH;
        pc_adv    = pc + ADDR_W'(1);
        adv_err   = err;
        if (&pc) begin
            adv_state = S_DONE;
            pc_adv    = pc;
            adv_err   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            step   <= '0;
            k_last <= '0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            pc     <= pc_next;
            step   <= step_next;
            k_last <= k_last_next;
            err    <= err_next;
        end
    end

    always_comb begin
        next_state  = state;
        pc_next     = pc;
        step_next   = step;
        k_last_next = k_last;
        err_next    = err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                    pc_next    = '0;
                end
            end
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (inst_data[15:12])
                    OP_NOP: begin
                        next_state = adv_state;
                        pc_next    = pc_adv;
                        err_next   = adv_err;
                    end
                    OP_CLR: next_state = S_CLR;
                    OP_MAC: begin
                        next_state  = S_MAC;
                        step_next   = '0;
                        k_last_next = k_op;
                    end
                    OP_STORE: begin
                        next_state = S_STORE;
                        step_next  = '0;
                    end
                    OP_HALT: next_state = S_DONE;
                    default: begin
                        next_state = S_DONE;
                        err_next   = 1'b1;
                    end
                endcase
            end
            S_CLR, S_DRAIN: begin
                next_state = adv_state;
                pc_next    = pc_adv;
                err_next   = adv_err;
            end
            S_MAC: begin
                if (step == k_last) begin
                    next_state = S_DRAIN;
                end else begin
                    step_next = step + 2'd1;
                end
            end
            S_STORE: begin
                if (step == 2'd3) begin
                    next_state = adv_state;
                    pc_next    = pc_adv;
                    err_next   = adv_err;
                end else begin
                    step_next = step + 2'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    next_state = S_FETCH;
                    pc_next    = '0;
                    err_next   = 1'b0;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output values are decoded from the upcoming state so the registered
    // strobes line up with the state they belong to.
    always_comb begin
        inst_addr_d  = pc_next;
        inst_rd_en_d = (next_state == S_FETCH);
        op_rd_en_d   = (next_state == S_MAC);
        op_k_d       = (next_state == S_MAC) ? step_next : 2'd0;
        pe_clr_d     = (next_state == S_CLR);
        res_wr_en_d  = (next_state == S_STORE);
        res_row_d    = (next_state == S_STORE) ? step_next : 2'd0;
        busy_d       = (next_state != S_IDLE) && (next_state != S_DONE);
        stop_d       = (next_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_addr  <= '0;
            inst_rd_en <= 1'b0;
            op_rd_en   <= 1'b0;
            op_k       <= 2'd0;
            pe_clr     <= 1'b0;
            pe_acc_en  <= 1'b0;
            res_wr_en  <= 1'b0;
            res_row    <= 2'd0;
            busy       <= 1'b0;
            stop       <= 1'b0;
        end else begin
            inst_addr  <= inst_addr_d;
            inst_rd_en <= inst_rd_en_d;
            op_rd_en   <= op_rd_en_d;
            op_k       <= op_k_d;
            pe_clr     <= pe_clr_d;
            pe_acc_en  <= op_rd_en;
            res_wr_en  <= res_wr_en_d;
            res_row    <= res_row_d;
            busy       <= busy_d;
            stop       <= stop_d;
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: directed programs push expected strobe
// events, a negedge monitor pops and compares them as the DUT emits strobes.
module tb_pe_sequencer;

    localparam int EV_CLR  = 0;
    localparam int EV_RD   = 1;
    localparam int EV_ACC  = 2;
    localparam int EV_WR   = 3;
    localparam int EV_STOP = 4;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;

    logic [7:0]  inst_addr;
    logic        inst_rd_en;
    logic [15:0] inst_data = 16'h0000;
    logic        op_rd_en;
    logic [1:0]  op_k;
    logic        pe_clr;
    logic        pe_acc_en;
    logic        res_wr_en;
    logic [1:0]  res_row;
    logic        busy;
    logic        stop;
    logic        err;

    logic [1:0]  inst_addr2;
    logic        inst_rd_en2;
    logic [15:0] inst_data2 = 16'h0000;
    logic        op_rd_en2;
    logic [1:0]  op_k2;
    logic        pe_clr2;
    logic        pe_acc_en2;
    logic        res_wr_en2;
    logic [1:0]  res_row2;
    logic        busy2;
    logic        stop2;
    logic        err2;

    logic [15:0] mem  [256];
    logic [15:0] mem2 [4];

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    pe_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .inst_addr(inst_addr), .inst_rd_en(inst_rd_en), .inst_data(inst_data),
        .op_rd_en(op_rd_en), .op_k(op_k), .pe_clr(pe_clr), .pe_acc_en(pe_acc_en),
        .res_wr_en(res_wr_en), .res_row(res_row),
        .busy(busy), .stop(stop), .err(err)
    );

    pe_sequencer #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .inst_addr(inst_addr2), .inst_rd_en(inst_rd_en2), .inst_data(inst_data2),
        .op_rd_en(op_rd_en2), .op_k(op_k2), .pe_clr(pe_clr2), .pe_acc_en(pe_acc_en2),
        .res_wr_en(res_wr_en2), .res_row(res_row2),
        .busy(busy2), .stop(stop2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (inst_rd_en) inst_data <= mem[inst_addr];
    always @(posedge clk) if (inst_rd_en2) inst_data2 <= mem2[inst_addr2];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic sb_check(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d, want no event at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL event_order: got kind=%0d val=%0d, want kind=%0d val=%0d at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    function automatic void push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    // Monitor: pe_acc_en is matched with the op_k of the read one cycle earlier.
    int prev_rd = 0;
    int prev_k = 0;
    int prev_stop = 0;
    always @(negedge clk) begin
        int n;
        if (rst) begin
            prev_rd = 0;
            prev_k = 0;
            prev_stop = 0;
        end else begin
            chk("acc_follows_rd", int'(pe_acc_en), prev_rd);
            n = int'(pe_clr) + int'(op_rd_en) + int'(pe_acc_en) + int'(res_wr_en);
            chk("strobe_exclusive", int'(n <= 1 || (n == 2 && op_rd_en && pe_acc_en)), 1);
            if (pe_clr) sb_check(EV_CLR, 0);
            if (pe_acc_en) sb_check(EV_ACC, prev_k);
            if (op_rd_en) sb_check(EV_RD, int'(op_k));
            if (res_wr_en) sb_check(EV_WR, int'(res_row));
            if (stop && prev_stop == 0) sb_check(EV_STOP, int'(err));
            if (stop) chk("done_quiet", int'({busy, inst_rd_en, op_rd_en, pe_clr, pe_acc_en, res_wr_en}), 0);
            chk("dut2_no_datapath", int'({op_rd_en2, pe_clr2, pe_acc_en2, res_wr_en2}), 0);
            prev_rd = int'(op_rd_en);
            if (op_rd_en) prev_k = int'(op_k);
            prev_stop = int'(stop);
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, " inst_addr"}, int'(inst_addr), 0);
        chk({tag, " inst_rd_en"}, int'(inst_rd_en), 0);
        chk({tag, " op_rd_en"}, int'(op_rd_en), 0);
        chk({tag, " op_k"}, int'(op_k), 0);
        chk({tag, " pe_clr"}, int'(pe_clr), 0);
        chk({tag, " pe_acc_en"}, int'(pe_acc_en), 0);
        chk({tag, " res_wr_en"}, int'(res_wr_en), 0);
        chk({tag, " res_row"}, int'(res_row), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " stop"}, int'(stop), 0);
        chk({tag, " err"}, int'(err), 0);
    endtask

    task automatic load_prog_a();
        mem[0] = 16'h1000;
        mem[1] = 16'h2003;
        mem[2] = 16'h3000;
        mem[3] = 16'hF000;
    endtask

    task automatic push_prog_a();
        push(EV_CLR, 0);
        for (int k = 0; k < 4; k++) begin
            push(EV_RD, k);
            push(EV_ACC, k);
        end
        for (int r = 0; r < 4; r++) push(EV_WR, r);
        push(EV_STOP, 0);
    endtask

    // Cycle count covers the start cycle through the first cycle showing stop.
    task automatic run(input string name, input int want_cycles, input bit mid_start);
        int cnt;
        bit seen;
        bit pulsed;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 1;
        seen = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (start) start = 1'b0;
            if (mid_start && !pulsed && op_rd_en && op_k == 2'd1) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (stop) seen = 1'b1;
        end
        chk({name, " stop_reached"}, int'(seen), 1);
        chk({name, " start_to_stop_cycles"}, cnt, want_cycles);
        @(posedge clk); #1;
        chk({name, " scoreboard_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        int cnt;
        int addrs[$];

        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 4; i++) mem2[i] = 16'h0000;

        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset busy", int'(busy), 0);
        chk("idle_after_reset inst_rd_en", int'(inst_rd_en), 0);

        // CLR, MAC K=4, STORE, HALT: 1 + 3 + 7 + 6 + 2 + 1 cycles
        load_prog_a();
        push_prog_a();
        run("prog_a", 20, 1'b0);
        chk("prog_a err", int'(err), 0);

        mem[0] = 16'h5000;
        push(EV_STOP, 1);
        run("illegal", 4, 1'b0);
        chk("illegal err", int'(err), 1);
        chk("illegal stop", int'(stop), 1);

        mem[0] = 16'h2000;
        mem[1] = 16'hF000;
        push(EV_RD, 0);
        push(EV_ACC, 0);
        push(EV_STOP, 0);
        run("mac_k1", 8, 1'b0);
        chk("mac_k1 err_cleared", int'(err), 0);

        mem[0] = 16'h0000;
        mem[1] = 16'h3000;
        mem[2] = 16'hF000;
        for (int r = 0; r < 4; r++) push(EV_WR, r);
        push(EV_STOP, 0);
        run("nop_store", 12, 1'b0);

        load_prog_a();
        push_prog_a();
        run("start_in_mac", 20, 1'b1);

        // Reset in the cycle after the op_k=1 read: ACC1 and later strobes must never appear.
        push(EV_CLR, 0);
        push(EV_RD, 0);
        push(EV_ACC, 0);
        push(EV_RD, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (op_rd_en && op_k == 2'd1) found = 1'b1;
        end
        chk("mid_mac reached_k1", int'(found), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_reset("mid_mac");
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_mac idle busy", int'(busy), 0);
        chk("mid_mac idle stop", int'(stop), 0);
        chk("mid_mac scoreboard_drained", exp_q.size(), 0);

        push_prog_a();
        run("rerun_after_rst", 20, 1'b0);

        // Four NOPs with a 2-bit pc: overflow past address 3 ends with err.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cnt = 1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            cnt++;
            if (inst_rd_en2) addrs.push_back(int'(inst_addr2));
            if (stop2) found = 1'b1;
        end
        chk("wrap stop_reached", int'(found), 1);
        chk("wrap cycles", cnt, 10);
        chk("wrap err", int'(err2), 1);
        chk("wrap fetch_count", addrs.size(), 4);
        for (int i = 0; i < addrs.size(); i++) chk("wrap fetch_addr", addrs[i], i);

        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        @(negedge clk);
        chk("restart stop_cleared", int'(stop2), 0);
        chk("restart err_cleared", int'(err2), 0);
        chk("restart busy", int'(busy2), 1);
        chk("restart inst_rd_en", int'(inst_rd_en2), 1);
        chk("restart inst_addr", int'(inst_addr2), 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (stop2) found = 1'b1;
        end
        chk("restart stop_reached", int'(found), 1);
        chk("restart err", int'(err2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
